// File: rtl/traffic_lights_pkg.sv
// Shared types, lamp encodings and default timing for the intersection controller.
// Lamp vectors are {red,yellow,green}; every decoded pair keeps at least one road on red.
package traffic_lights_pkg;

  typedef enum logic [2:0] {
    MAIN_GREEN    = 3'd0,
    MAIN_YELLOW   = 3'd1,
    CLEAR_TO_SIDE = 3'd2,
    SIDE_GREEN    = 3'd3,
    SIDE_YELLOW   = 3'd4,
    CLEAR_TO_MAIN = 3'd5
  } lightState_t;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  localparam int DEF_MAIN_MIN_GREEN  = 4;
  localparam int DEF_YELLOW_TIME     = 2;
  localparam int DEF_ALL_RED_TIME    = 1;
  localparam int DEF_SIDE_GREEN_TIME = 4;
  localparam int DEF_SIDE_MAX_GREEN  = 8;
  localparam int DEF_CNT_W           = 8;

  // Returns {main, side}; an unknown encoding decodes to all-red.
  function automatic logic [5:0] lampsFor(input lightState_t st);
    logic [5:0] lamps;
    case (st)
      MAIN_GREEN:    lamps = {LAMP_GREEN,  LAMP_RED};
      MAIN_YELLOW:   lamps = {LAMP_YELLOW, LAMP_RED};
      CLEAR_TO_SIDE: lamps = {LAMP_RED,    LAMP_RED};
      SIDE_GREEN:    lamps = {LAMP_RED,    LAMP_GREEN};
      SIDE_YELLOW:   lamps = {LAMP_RED,    LAMP_YELLOW};
      CLEAR_TO_MAIN: lamps = {LAMP_RED,    LAMP_RED};
      default:       lamps = {LAMP_RED,    LAMP_RED};
    endcase
    return lamps;
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Per-phase cycle counter: clears on a phase change, otherwise counts up,
// optionally holding at SAT_MAX so a resting phase never wraps.
module tl_phase_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] SAT_MAX = {CNT_W{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             satEn,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] countR;

  // Counter register with clear priority over saturation and increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      countR <= CNT_ZERO;
    end else if (clear) begin
      countR <= CNT_ZERO;
    end else if (satEn && (countR == SAT_MAX)) begin
      countR <= countR;
    end else begin
      countR <= countR + CNT_ONE;
    end
  end

  assign count = countR;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road demand-actuated traffic-light controller (Moore FSM, registered lamps).
// Optional macro TRAFFIC_LIGHTS_SIDE_EXTEND_EN lets a waiting side vehicle extend side green up to SIDE_MAX_GREEN.
module traffic_light_ctrl
  import traffic_lights_pkg::*;
#(
  parameter int MAIN_MIN_GREEN  = DEF_MAIN_MIN_GREEN,
  parameter int YELLOW_TIME     = DEF_YELLOW_TIME,
  parameter int ALL_RED_TIME    = DEF_ALL_RED_TIME,
  parameter int SIDE_GREEN_TIME = DEF_SIDE_GREEN_TIME,
  parameter int CNT_W           = DEF_CNT_W
`ifdef TRAFFIC_LIGHTS_SIDE_EXTEND_EN
  ,
  parameter int SIDE_MAX_GREEN  = DEF_SIDE_MAX_GREEN
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       VehiclePresent,
  output logic [2:0] MainLights,
  output logic [2:0] SideLights
);

  localparam logic [CNT_W-1:0] MAIN_LAST   = CNT_W'(MAIN_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST  = CNT_W'(ALL_RED_TIME - 1);
  localparam logic [CNT_W-1:0] SIDE_LAST   = CNT_W'(SIDE_GREEN_TIME - 1);
`ifdef TRAFFIC_LIGHTS_SIDE_EXTEND_EN
  localparam logic [CNT_W-1:0] SIDE_MAX_LAST = CNT_W'(SIDE_MAX_GREEN - 1);
`endif

  lightState_t      stateR;
  lightState_t      nextStateS;
  logic [CNT_W-1:0] countS;
  logic             timerClearS;
  logic             satEnS;

  tl_phase_timer #(
    .CNT_W   (CNT_W),
    .SAT_MAX (MAIN_LAST)
  ) phaseTimer (
    .clk   (clk),
    .rst   (rst),
    .clear (timerClearS),
    .satEn (satEnS),
    .count (countS)
  );

  // Next-state decision; the timer restarts exactly when the state changes.
  always_comb begin
    nextStateS = stateR;
    case (stateR)
      MAIN_GREEN: begin
        if ((countS == MAIN_LAST) && VehiclePresent) nextStateS = MAIN_YELLOW;
        else nextStateS = MAIN_GREEN;
      end
      MAIN_YELLOW: begin
        if (countS == YELLOW_LAST) nextStateS = CLEAR_TO_SIDE;
        else nextStateS = MAIN_YELLOW;
      end
      CLEAR_TO_SIDE: begin
        if (countS == CLEAR_LAST) nextStateS = SIDE_GREEN;
        else nextStateS = CLEAR_TO_SIDE;
      end
      SIDE_GREEN: begin
`ifdef TRAFFIC_LIGHTS_SIDE_EXTEND_EN
        // Past the base time, stay green while a vehicle waits, up to the cap.
        if ((countS >= SIDE_LAST) && (!VehiclePresent || (countS == SIDE_MAX_LAST)))
          nextStateS = SIDE_YELLOW;
        else nextStateS = SIDE_GREEN;
`else
        if (countS == SIDE_LAST) nextStateS = SIDE_YELLOW;
        else nextStateS = SIDE_GREEN;
`endif
      end
      SIDE_YELLOW: begin
        if (countS == YELLOW_LAST) nextStateS = CLEAR_TO_MAIN;
        else nextStateS = SIDE_YELLOW;
      end
      CLEAR_TO_MAIN: begin
        if (countS == CLEAR_LAST) nextStateS = MAIN_GREEN;
        else nextStateS = CLEAR_TO_MAIN;
      end
      default: nextStateS = MAIN_GREEN;
    endcase
    timerClearS = (nextStateS != stateR);
    satEnS      = (stateR == MAIN_GREEN);
  end

  // State register; lamps are registered alongside so they always match the state held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateR     <= MAIN_GREEN;
      MainLights <= LAMP_GREEN;
      SideLights <= LAMP_RED;
    end else begin
      stateR                   <= nextStateS;
      {MainLights, SideLights} <= lampsFor(nextStateS);
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench: the driver queues hand-derived lamp pairs per clock,
// a monitor pops and compares after each edge and checks the red-interlock every cycle.
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       VehiclePresent;
  logic [2:0] MainLights;
  logic [2:0] SideLights;

  typedef struct {
    logic [2:0] mainExp;
    logic [2:0] sideExp;
    string      tag;
    int         idx;
  } expItem_t;

  expItem_t expQ[$];
  int compared   = 0;
  int mismatched = 0;

  traffic_light_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .VehiclePresent (VehiclePresent),
    .MainLights     (MainLights),
    .SideLights     (SideLights)
  );

  always #5 clk = ~clk;

  // Phase letters: G main green, Y main yellow, C all red, S side green, s side yellow.
  function automatic logic [5:0] phaseLamps(input byte ph);
    case (ph)
      "G":     return 6'b001_100;
      "Y":     return 6'b010_100;
      "C":     return 6'b100_100;
      "S":     return 6'b100_001;
      "s":     return 6'b100_010;
      default: return 6'b000_000;
    endcase
  endfunction

  task automatic checkLamps(input string tag, input int idx,
                            input logic [2:0] expMain, input logic [2:0] expSide);
    compared++;
    if ({MainLights, SideLights} !== {expMain, expSide}) begin
      mismatched++;
      $display("FAIL %s[%0d]: lamps main/side got %b/%b, expected %b/%b",
               tag, idx, MainLights, SideLights, expMain, expSide);
    end
  endtask

  // One entry per clock: vps[i] is the sensor level before edge i (last char repeats).
  task automatic runSeq(input string tag, input string vps, input string phases);
    for (int i = 0; i < phases.len(); i++) begin
      expItem_t   e;
      logic [5:0] l;
      int         vi;
      vi = (i < vps.len()) ? i : vps.len() - 1;
      VehiclePresent = (vps.getc(vi) == 8'h31);
      l = phaseLamps(phases.getc(i));
      e.mainExp = l[5:3];
      e.sideExp = l[2:0];
      e.tag     = tag;
      e.idx     = i + 1;
      expQ.push_back(e);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Called at a negedge: reset must show main-green immediately and across an edge.
  task automatic doReset(input string tag);
    rst = 1'b0;
    VehiclePresent = 1'b0;
    #1;
    checkLamps(tag, 0, 3'b001, 3'b100);
    @(posedge clk);
    #1;
    checkLamps(tag, 1, 3'b001, 3'b100);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: after every edge check the interlock, then any queued expectation.
  initial begin
    forever begin
      expItem_t e;
      @(posedge clk);
      #1;
      compared++;
      if (!((MainLights == 3'b100) || (SideLights == 3'b100)) ||
          !$onehot(MainLights) || !$onehot(SideLights)) begin
        mismatched++;
        $display("FAIL safety: lamps main/side got %b/%b, required one-hot with a red road",
                 MainLights, SideLights);
      end
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkLamps(e.tag, e.idx, e.mainExp, e.sideExp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d checks, expected completion", compared);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    VehiclePresent = 1'b0;
    @(negedge clk);
    doReset("porReset");
    runSeq("noDemand", "0", "GGGGGGGGGGGGGGGGGGGG");
    runSeq("demandAfterMin", "10", "YYCSSSSssCGG");
    doReset("preEarly");
`ifdef TRAFFIC_LIGHTS_SIDE_EXTEND_EN
    runSeq("earlyDemand", "1", "GGGYYCSSSSSSSSssCGGGGYYCSS");
`else
    runSeq("earlyDemand", "1", "GGGYYCSSSSssCGGGGYYCSS");
`endif
    doReset("midSideReset");
    runSeq("shortPulse", "110", "GGGGGGGGGGGG");
`ifdef TRAFFIC_LIGHTS_SIDE_EXTEND_EN
    doReset("preExtend");
    runSeq("extendDrop", "1111111111110", "GGGYYCSSSSSSssCG");
`endif
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
